// File: rtl/package_settings.sv
// Shared settings for the arctangent / phase-unwrap chain.
package package_settings;

    // Phase and frequency sample width.
    localparam int SIZE_DATA = 16;
    // Unwrapped-phase accumulator width; must exceed SIZE_DATA.
    localparam int SIZE_ACC  = 32;
    // Phase LSB count that represents pi.
    localparam int PHASE_PI  = 2 ** (SIZE_DATA - 1);

    typedef logic signed [SIZE_DATA-1:0] phase_t;
    typedef logic signed [SIZE_ACC-1:0]  acc_t;

    // Sign-extend a wrapped phase or delta to accumulator width.
    function automatic acc_t sign_ext(input phase_t p);
        return {{(SIZE_ACC - SIZE_DATA){p[SIZE_DATA-1]}}, p};
    endfunction

endpackage

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice: an output register plus one skid
// register, so a stall is absorbed without dropping the sample in flight.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; valid never waits on ready, and out_data holds steady while
// out_valid && !out_ready.
module skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic             in_ready_q, in_ready_d;
    logic             push;
    logic             pop;

    // Next-state of both entries; a pop with a full skid promotes the skid
    // entry before any new sample is placed.
    always_comb begin
        push         = in_valid && in_ready_q;
        pop          = out_valid_q && out_ready;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            // Everything held is discarded; a same-cycle sample starts fresh.
            out_valid_d  = push;
            out_data_d   = push ? in_data : '0;
            skid_valid_d = 1'b0;
            skid_data_d  = '0;
        end else if (pop) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                out_valid_d  = 1'b1;
                skid_valid_d = push;
                if (push) begin
                    skid_data_d = in_data;
                end
            end else begin
                out_valid_d = push;
                if (push) begin
                    out_data_d = in_data;
                end
            end
        end else if (push) begin
            if (!out_valid_q) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end
        end
        in_ready_d = !skid_valid_d;
    end

    // Register both entries and the registered ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: rtl/phase_unwrap.sv
// Phase unwrapper: turns wrapped +/-pi phase samples into a wide unwrapped
// phase accumulator and a wrapped first difference (instantaneous frequency).
// Handshake: input and output transfers happen on a rising clk edge where the
// respective valid && ready are both high; outputs hold while stalled.
module phase_unwrap
    import package_settings::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic [SIZE_DATA-1:0] in_phase,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SIZE_ACC-1:0]  out_phase,
    output logic [SIZE_DATA-1:0] out_freq,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 acc_wrap
);

    localparam int WIDTH = SIZE_ACC + SIZE_DATA;

    phase_t     prev_q, prev_d;
    logic       primed_q, primed_d;
    acc_t       acc_q, acc_d;
    logic       acc_wrap_q, acc_wrap_d;

    phase_t     diff;
    phase_t     freq;
    acc_t       diff_ext;
    acc_t       sum;
    logic       ovf;
    logic       push;
    logic       first;
    logic [WIDTH-1:0] slice_out;

    // Unwrap datapath: the difference wraps naturally in SIZE_DATA bits, so
    // it is always the shortest path and -pi is the tie case.
    always_comb begin
        push       = in_valid && in_ready;
        first      = !primed_q || clear;
        diff       = in_phase - prev_q;
        diff_ext   = sign_ext(diff);
        sum        = acc_q + diff_ext;
        ovf        = (acc_q[SIZE_ACC-1] == diff_ext[SIZE_ACC-1]) &&
                     (sum[SIZE_ACC-1] != acc_q[SIZE_ACC-1]);
        prev_d     = prev_q;
        primed_d   = primed_q;
        acc_d      = acc_q;
        acc_wrap_d = acc_wrap_q;
        freq       = '0;
        if (clear) begin
            prev_d     = '0;
            primed_d   = 1'b0;
            acc_d      = '0;
            acc_wrap_d = 1'b0;
        end
        if (push) begin
            prev_d = in_phase;
            if (first) begin
                acc_d    = sign_ext(in_phase);
                primed_d = 1'b1;
            end else begin
                acc_d = sum;
                freq  = diff;
                if (ovf) begin
                    acc_wrap_d = 1'b1;
                end
            end
        end
    end

    // Datapath state.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q     <= '0;
            primed_q   <= 1'b0;
            acc_q      <= '0;
            acc_wrap_q <= 1'b0;
        end else begin
            prev_q     <= prev_d;
            primed_q   <= primed_d;
            acc_q      <= acc_d;
            acc_wrap_q <= acc_wrap_d;
        end
    end

    skid_buffer #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .flush     (clear),
        .in_data   ({acc_d, freq}),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (slice_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_phase = slice_out[WIDTH-1:SIZE_DATA];
    assign out_freq  = slice_out[SIZE_DATA-1:0];
    assign acc_wrap  = acc_wrap_q;

endmodule

// File: tb/tb_phase_unwrap.sv
// Bench for phase_unwrap: random and directed stimulus, an unbounded-integer
// reference model feeding an expected queue, and a decoupled output monitor.
module tb_phase_unwrap;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear;
  logic [15:0] in_phase;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_phase;
  logic [15:0] out_freq;
  logic        out_valid;
  logic        out_ready;
  logic        acc_wrap;

  int compared = 0;
  int mismatched = 0;

  logic [47:0] exp_q[$];

  // reference model state
  longint u_m = 0;
  int     prev_m = 0;
  bit     primed_m = 0;
  bit     wrap_m = 0;

  // monitor state
  logic [31:0] last_phase = '0;
  logic [15:0] last_freq = '0;
  int          n_out = 0;
  bit          hold_pend = 0;
  logic [31:0] hold_phase;
  logic [15:0] hold_freq;

  phase_unwrap dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_phase  (in_phase),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_phase (out_phase),
    .out_freq  (out_freq),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_wrap  (acc_wrap)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  task automatic model_push(input logic [15:0] x);
    int xs;
    int d;
    int f;
    logic [47:0] e;
    xs = int'($signed(x));
    if (!primed_m) begin
      u_m = longint'(xs);
      f = 0;
      primed_m = 1;
    end else begin
      d = (((xs - prev_m) + 98304) % 65536) - 32768;
      u_m = u_m + longint'(d);
      f = d;
    end
    prev_m = xs;
    if (u_m > 64'sd2147483647 || u_m < -64'sd2147483648) wrap_m = 1;
    e = {u_m[31:0], f[15:0]};
    exp_q.push_back(e);
  endtask

  // input-side capture: sees every accepted sample, clear and reset
  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      exp_q.delete();
      primed_m = 0;
      wrap_m = 0;
    end else begin
      if (clear) begin
        exp_q.delete();
        primed_m = 0;
        wrap_m = 0;
      end
      if (in_valid && in_ready) model_push(in_phase);
    end
  end

  // output monitor: pops and compares on every output transfer
  always @(negedge clk) begin
    logic [47:0] e;
    if (hold_pend) begin
      compared++;
      if (!out_valid || out_phase !== hold_phase || out_freq !== hold_freq) begin
        mismatched++;
        $display("FAIL hold: got v=%0b %h/%h required v=1 %h/%h", out_valid, out_phase, out_freq,
                 hold_phase, hold_freq);
      end
      hold_pend = 0;
    end
    if (out_valid && out_ready && !reset) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL out_unexpected: got %h/%h required no output", out_phase, out_freq);
      end else begin
        e = exp_q.pop_front();
        if ({out_phase, out_freq} !== e) begin
          mismatched++;
          $display("FAIL out_data: got %h/%h required %h/%h", out_phase, out_freq, e[47:16], e[15:0]);
        end
      end
      last_phase = out_phase;
      last_freq = out_freq;
      n_out++;
    end
    if (out_valid && !out_ready && !reset && !clear) begin
      hold_pend = 1;
      hold_phase = out_phase;
      hold_freq = out_freq;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // present one sample and hold it until accepted; returns at posedge+1
  task automatic send(input logic [15:0] x);
    bit ok;
    int n;
    n = 0;
    in_phase = x;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 100);
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: got in_ready=0 for 100 clk required acceptance");
    end
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // wait until every expected output has been seen; returns at posedge+1
  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    @(negedge clk);
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] x;
    logic [15:0] rand_prev;
    bit taken;
    int base;

    reset = 1'b1;
    clear = 1'b0;
    in_phase = '0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset values
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_phase", out_phase, 32'd0);
    check("rst_out_freq", 32'(out_freq), 32'd0);
    check("rst_acc_wrap", 32'(acc_wrap), 32'd0);
    @(posedge clk);
    #1;

    // prime, one clock latency
    send(16'h1000);
    in_valid = 1'b0;
    @(negedge clk);
    check("prime_latency", 32'(out_valid), 32'd1);
    check("prime_phase", out_phase, 32'h0000_1000);
    check("prime_freq", 32'(out_freq), 32'd0);
    drain();

    // positive wrap
    pulse_clear();
    send(16'h7000);
    send(16'h9000);
    drain();
    check("pos_wrap_phase", last_phase, 32'h0000_9000);
    check("pos_wrap_freq", 32'(last_freq), 32'h2000);
    send(16'hB000);
    drain();
    check("pos_wrap_next", last_phase, 32'h0000_B000);

    // negative wrap
    pulse_clear();
    send(16'h9000);
    send(16'h7000);
    drain();
    check("neg_wrap_phase", last_phase, 32'hFFFF_7000);
    check("neg_wrap_freq", 32'(last_freq), 32'hE000);

    // exact -pi tie
    pulse_clear();
    send(16'h0000);
    send(16'h8000);
    drain();
    check("tie_phase", last_phase, 32'hFFFF_8000);
    check("tie_freq", 32'(last_freq), 32'h8000);

    // back-pressure: 5 clk stall while streaming 0..9
    pulse_clear();
    base = n_out;
    fork
      begin
        for (int i = 0; i < 10; i++) send(16'(i));
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check("bp_count", 32'(n_out - base), 32'd10);
    check("bp_last_phase", last_phase, 32'd9);
    check("bp_last_freq", 32'(last_freq), 32'd1);

    // accumulator overflow with maximum positive steps
    pulse_clear();
    x = 16'h7FFF;
    for (int i = 0; i < 65538; i++) begin
      send(x);
      x = x + 16'h7FFF;
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("ovf_not_yet", 32'(acc_wrap), 32'd0);
    @(posedge clk);
    #1;
    send(x);
    drain();
    check("ovf_sticky", 32'(acc_wrap), 32'd1);
    check("ovf_model_flag", 32'(acc_wrap), 32'(wrap_m));
    check("ovf_phase", last_phase, 32'h8000_7FFD);
    pulse_clear();
    @(negedge clk);
    check("ovf_cleared", 32'(acc_wrap), 32'd0);
    @(posedge clk);
    #1;
    send(16'h1234);
    drain();
    check("reprime_phase", last_phase, 32'h0000_1234);
    check("reprime_freq", 32'(last_freq), 32'd0);

    // reset while both entries are full
    out_ready = 1'b0;
    send(16'h0100);
    send(16'h0200);
    in_valid = 1'b0;
    @(negedge clk);
    check("full_out_valid", 32'(out_valid), 32'd1);
    check("full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_out_phase", out_phase, 32'd0);
    out_ready = 1'b1;
    base = n_out;
    repeat (5) @(negedge clk);
    check("mid_rst_no_stale", 32'(n_out - base), 32'd0);
    @(posedge clk);
    #1;
    send(16'h0300);
    drain();
    check("post_rst_phase", last_phase, 32'h0000_0300);

    // randomized traffic with stalls and occasional clears
    rand_prev = 16'h0;
    in_valid = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      taken = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || taken) begin
        in_valid = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 2))
          0: rand_prev = 16'($urandom_range(0, 65535));
          1: rand_prev = rand_prev + 16'($urandom_range(0, 4095)) - 16'd2048;
          default: rand_prev = rand_prev + 16'h8000;
        endcase
        in_phase = rand_prev;
      end
      out_ready = ($urandom_range(0, 3) != 0);
      clear = ($urandom_range(0, 63) == 0);
    end
    clear = 1'b0;
    out_ready = 1'b1;
    drain();
    check("rand_acc_wrap", 32'(acc_wrap), 32'(wrap_m));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
